// File: rtl/fpu_share_arbiter.sv
// Round-robin share of one combinational FP adder among NUM_REQ requesters.
// Optional macro FPU_ARB_ZERO_SKIP_EN returns the other operand directly when one operand is +/-0.
module fpu_share_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int ID_W     = 2,
    parameter int FPU_WAIT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_in1,
    input  logic [32*NUM_REQ-1:0] req_in2,
    output logic [NUM_REQ-1:0]    rsp_valid,
    input  logic [NUM_REQ-1:0]    rsp_ready,
    output logic [31:0]           rsp_data,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           fpu_in1,
    output logic [31:0]           fpu_in2,
    input  logic [31:0]           fpu_out
);

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ID_W-1:0]    last_grant_q, last_grant_d;
    logic [ID_W-1:0]    rsp_id_q, rsp_id_d;
    logic [31:0]        rsp_data_q, rsp_data_d;
    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [31:0]        fpu_in1_q, fpu_in1_d;
    logic [31:0]        fpu_in2_q, fpu_in2_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [31:0]        in1_arr [NUM_REQ];
    logic [31:0]        in2_arr [NUM_REQ];
    logic               grant_found;
    logic [ID_W-1:0]    grant_idx;
    logic [31:0]        sel_in1;
    logic [31:0]        sel_in2;
    int                 cand;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign in1_arr[k] = req_in1[32*k +: 32];
        assign in2_arr[k] = req_in2[32*k +: 32];
    end

    // Search starts just past the last answered requester, so it drops to lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = (int'(last_grant_q) + i) % NUM_REQ;
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = ID_W'(cand);
            end
        end
    end

    assign sel_in1 = in1_arr[grant_idx];
    assign sel_in2 = in2_arr[grant_idx];

    // Valid/ready: a transfer happens on a rising edge where both valid and ready are high;
    // req_ready depends on req_valid only in IDLE, and rsp_valid never waits on rsp_ready.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && grant_found) begin
            req_ready = NUM_REQ'(1) << grant_idx;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rsp_id_d     = rsp_id_q;
        rsp_data_d   = rsp_data_q;
        rsp_valid_d  = rsp_valid_q;
        fpu_in1_d    = fpu_in1_q;
        fpu_in2_d    = fpu_in2_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_found) begin
                    fpu_in1_d = sel_in1;
                    fpu_in2_d = sel_in2;
                    rsp_id_d  = grant_idx;
                    cnt_d     = '0;
                    state_d   = EXEC;
`ifdef FPU_ARB_ZERO_SKIP_EN
                    if (sel_in2[30:0] == 31'd0) begin
                        rsp_data_d  = sel_in1;
                        rsp_valid_d = NUM_REQ'(1) << grant_idx;
                        state_d     = RESP;
                    end else if (sel_in1[30:0] == 31'd0) begin
                        rsp_data_d  = sel_in2;
                        rsp_valid_d = NUM_REQ'(1) << grant_idx;
                        state_d     = RESP;
                    end
`endif
                end
            end
            EXEC: begin
                if (cnt_q == CNT_W'(FPU_WAIT - 1)) begin
                    rsp_data_d  = fpu_out;
                    rsp_valid_d = NUM_REQ'(1) << rsp_id_q;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                if (rsp_ready[rsp_id_q]) begin
                    last_grant_d = rsp_id_q;
                    rsp_valid_d  = '0;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_W'(NUM_REQ - 1);
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_valid_q  <= '0;
            fpu_in1_q    <= '0;
            fpu_in2_q    <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            rsp_id_q     <= rsp_id_d;
            rsp_data_q   <= rsp_data_d;
            rsp_valid_q  <= rsp_valid_d;
            fpu_in1_q    <= fpu_in1_d;
            fpu_in2_q    <= fpu_in2_d;
            cnt_q        <= cnt_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign fpu_in1   = fpu_in1_q;
    assign fpu_in2   = fpu_in2_q;

endmodule
